scan_display_mux: RTL and testbench
===================================

SCAN_DISPLAY_MUX -- requirements
Module: scan_display_mux

Interface
REQ-001 The block SHALL have the parameter DIGITS, default 4, giving the number of multiplexed digits; the legal range SHALL be 1..8.
REQ-002 The block SHALL have the parameter DIV_W, default 13, giving the scan prescaler width; the legal range SHALL be DIV_W >= 4.
REQ-003 The block SHALL have the parameter BLINK_W, default 22, giving the blink counter width; the legal range SHALL be BLINK_W > DIV_W.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have the port bcd_in, input, 4*DIGITS bits: digit i sits at bcd_in[4i+3:4i], and digit 0 is the ones digit.
REQ-007 The block SHALL have the port dp_in, input, DIGITS bits: the decimal point for each digit (1 = lit).
REQ-008 The block SHALL have the port blink_en, input, DIGITS bits: per-digit blink enable.
REQ-009 The block SHALL have the port lz_blank, input, 1 bit: 1 = suppress leading zeros.
REQ-010 The block SHALL have the port brightness, input, 3 bits: on-time is (brightness+1)/8 of each digit slot.
REQ-011 The block SHALL have the port seg_sel, output, DIGITS bits: digit anodes, low-active; bit i drives digit i.
REQ-012 The block SHALL have the port seg_out, output, 8 bits: segments, low-active; [0]=a through [6]=g, [7]=dp.

Function
REQ-013 A free-running DIV_W-bit prescaler p SHALL increment every cycle and wrap; tick SHALL be asserted when p is all ones.
REQ-014 The digit index idx SHALL advance on tick through 0,1,...,DIGITS-1 and then wrap to 0; each digit slot SHALL therefore last 2^DIV_W cycles.
REQ-015 On the tick where idx == DIGITS-1, the block SHALL capture bcd_in, dp_in and blink_en into shadow registers; at all other times the displayed data SHALL be the shadow copy, so there is no mid-frame tearing.
REQ-016 lz_blank and brightness SHALL be used live, not shadowed.
REQ-017 The digit selected by idx SHALL be lit (its seg_sel bit 0 and all other bits 1) only when p[DIV_W-1:DIV_W-3] <= brightness; otherwise seg_sel SHALL be all ones.
REQ-018 A free-running BLINK_W-bit counter SHALL run, and its MSB SHALL be the blink phase; when the blink phase is 1 and shadow blink_en[idx] is 1, seg_sel SHALL be all ones for that slot.
REQ-019 Decoding SHALL map BCD 0-9 to standard glyphs, and values 10-15 SHALL show '-' (g only, seg_out[6:0] = 7'h3F).
REQ-020 Leading-zero suppression: when lz_blank is 1, digit i >= 1 SHALL be blank (seg_out[6:0] all ones) if shadow digits i..DIGITS-1 are all 0.
REQ-021 Digit 0 SHALL never be blanked by leading-zero suppression.
REQ-022 During leading-zero blanking, seg_sel SHALL stay active and dp SHALL still follow shadow dp_in.
REQ-023 seg_out[7] SHALL be the inverse of shadow dp_in[idx].
REQ-024 seg_sel and seg_out SHALL be registered, with 1-cycle latency from (p, idx, blink phase) to the outputs.
REQ-025 seg_out SHALL be driven with the selected digit's pattern even while its anode is off.
REQ-026 With DIGITS=1, idx SHALL stay at 0 and the shadow capture SHALL happen on every tick.

Reset
REQ-027 While rst is 1 on a clock edge, the block SHALL set p=0, idx=0, blink counter=0 and all shadow registers=0.
REQ-028 While rst is 1 on a clock edge, the block SHALL set seg_sel to all ones and seg_out to 8'hFF.
REQ-029 A reset asserted mid-frame SHALL take effect on the next edge, with no partial slot completed.
REQ-030 On the first edge after rst deasserts, the outputs SHALL show digit 0 from shadow data of zero, i.e. seg_out=8'hC0 when brightness permits.

Verification (DIGITS=4, DIV_W=4, BLINK_W=6)
REQ-031 Reset: hold rst for 3 cycles -> seg_sel=4'b1111 and seg_out=8'hFF; one cycle after release, seg_sel=4'b1110 and seg_out=8'hC0 (brightness=7).
REQ-032 Scan: bcd_in=16'h1234, dp_in=0, brightness=7, wait one frame -> digit0 seg_out=8'h99 (4), then 8'hB0 (3), 8'hA4 (2), 8'hF9 (1), each for 16 cycles with seg_sel 1110/1101/1011/0111; bcd_in changed mid-frame is not shown until the next frame.
REQ-033 Leading zeros: lz_blank=1, bcd_in=16'h0005, dp_in=4'b0100 -> digit3 seg_out=8'hFF, digit2 seg_out=8'h7F, digit1 seg_out=8'hFF, digit0 seg_out=8'h92, and seg_sel is active in all slots.
REQ-034 Brightness: brightness=0 -> within each 16-cycle slot, seg_sel is active only for the 2 cycles where p[3:1]=0 (1-cycle lag) and all ones for the other 14.
REQ-035 Blink: blink_en=4'b0010 -> digit1 slot seg_sel=4'b1111 whenever blink MSB=1 (32 of every 64 cycles) and 4'b1101 otherwise; other digits are unaffected.
REQ-036 Invalid BCD: bcd_in=16'h000A, lz_blank=0 -> digit0 seg_out=8'hBF, digits 1-3 seg_out=8'hC0.

Source files
------------

// File: rtl/scan_display_mux.sv
// Multiplexed 7-segment scanner: frame-shadowed BCD, leading-zero blank, blink, PWM brightness.
// Outputs registered, 1-cycle latency from scan state; no backpressure (free-running display).
module scan_display_mux #(
   parameter int DIGITS  = 4,
   parameter int DIV_W   = 13,
   parameter int BLINK_W = 22
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blink_en,
   input  logic                  lz_blank,
   input  logic [2:0]            brightness,
   output logic [DIGITS-1:0]     seg_sel,
   output logic [7:0]            seg_out
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [DIV_W-1:0]    p;
   logic [IDX_W-1:0]    idx;
   logic [BLINK_W-1:0]  blink_cnt;
   logic [4*DIGITS-1:0] bcd_sh;
   logic [DIGITS-1:0]   dp_sh;
   logic [DIGITS-1:0]   blink_sh;
   logic                tick;

   logic [DIGITS-1:0]   lz_vec;
   logic [3:0]          cur_bcd;
   logic                cur_dp;
   logic                cur_blink;
   logic                cur_lz;
   logic                lit;
   logic [6:0]          glyph;
   logic [DIGITS-1:0]   sel_nxt;
   logic                run_zero;

   assign tick = &p;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   // Scan state; shadows reload only as the last slot ends so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         p         <= '0;
         idx       <= '0;
         blink_cnt <= '0;
         bcd_sh    <= '0;
         dp_sh     <= '0;
         blink_sh  <= '0;
      end else begin
         p         <= p + DIV_W'(1);
         blink_cnt <= blink_cnt + BLINK_W'(1);
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
               bcd_sh   <= bcd_in;
               dp_sh    <= dp_in;
               blink_sh <= blink_en;
            end
         end
      end
   end

   always_comb begin
      lz_vec   = '0;
      run_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run_zero  = run_zero && (bcd_sh[4*i +: 4] == 4'd0);
         lz_vec[i] = run_zero && (i != 0);
      end

      cur_bcd   = '0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_bcd   = bcd_sh[4*i +: 4];
            cur_dp    = dp_sh[i];
            cur_blink = blink_sh[i];
            cur_lz    = lz_vec[i];
         end
      end

      glyph = (lz_blank && cur_lz) ? 7'h7F : decode(cur_bcd);
      lit   = (p[DIV_W-1 -: 3] <= brightness) && !(blink_cnt[BLINK_W-1] && cur_blink);

      sel_nxt = '1;
      for (int i = 0; i < DIGITS; i++) begin
         sel_nxt[i] = !(lit && (idx == IDX_W'(i)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_sel <= '1;
         seg_out <= 8'hFF;
      end else begin
         seg_sel <= sel_nxt;
         seg_out <= {~cur_dp, glyph};
      end
   end

endmodule

// File: tb/tb_scan_display_mux.sv
// Directed bench for scan_display_mux at DIGITS=4, DIV_W=4, BLINK_W=6 (16-cycle slots, 64-cycle frame).
module tb_scan_display_mux;

   logic        clk;
   logic        rst;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic [3:0]  blink_en;
   logic        lz_blank;
   logic [2:0]  brightness;
   logic [3:0]  seg_sel;
   logic [7:0]  seg_out;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt   = 0;

   scan_display_mux #(.DIGITS(4), .DIV_W(4), .BLINK_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .blink_en   (blink_en),
      .lz_blank   (lz_blank),
      .brightness (brightness),
      .seg_sel    (seg_sel),
      .seg_out    (seg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected anodes for output edge number c (1-based from reset release).
   function automatic logic [3:0] exp_sel(input int c, input logic [2:0] br, input logic [3:0] bm);
      int  pp;
      int  ix;
      bit  ph;
      pp = (c - 1) % 16;
      ix = ((c - 1) / 16) % 4;
      ph = ((c - 1) % 64) >= 32;
      if ((pp / 2) <= int'(br) && !(bm[ix] && ph)) return ~(4'b0001 << ix);
      return 4'hF;
   endfunction

   function automatic logic [7:0] exp_out(input int c, input logic [31:0] tbl);
      int ix;
      ix = ((c - 1) / 16) % 4;
      return tbl[ix*8 +: 8];
   endfunction

   task automatic step();
      @(posedge clk);
      cnt++;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b0;
      cnt = 0;
   endtask

   task automatic test_reset();
      bcd_in = 16'h1234; dp_in = 4'h0; blink_en = 4'h0; lz_blank = 1'b0; brightness = 3'd7;
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (seg_sel !== 4'b1111 || seg_out !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_hold: sel=%b out=%h want sel=1111 out=ff", seg_sel, seg_out);
         end
      end
      rst = 1'b0;
      cnt = 0;
      step();
      n_cmp++;
      if (seg_sel !== 4'b1110 || seg_out !== 8'hC0) begin
         n_bad++;
         $display("FAIL reset_release: sel=%b out=%h want sel=1110 out=c0", seg_sel, seg_out);
      end
   endtask

   task automatic test_scan();
      logic [31:0] tbl;
      bcd_in = 16'h1234; dp_in = 4'h0; blink_en = 4'h0; lz_blank = 1'b0; brightness = 3'd7;
      apply_reset();
      for (int f = 0; f < 3; f++) begin
         tbl = (f == 0) ? 32'hC0C0C0C0 : (f == 1) ? 32'hF9A4B099 : 32'h9282F880;
         for (int i = 0; i < 64; i++) begin
            step();
            if (f == 1 && i == 20) bcd_in = 16'h5678;
            n_cmp++;
            if (seg_sel !== exp_sel(cnt, 3'd7, 4'h0) || seg_out !== exp_out(cnt, tbl)) begin
               n_bad++;
               $display("FAIL scan f%0d c%0d: sel=%b out=%h want sel=%b out=%h",
                        f, cnt, seg_sel, seg_out, exp_sel(cnt, 3'd7, 4'h0), exp_out(cnt, tbl));
            end
         end
      end
   endtask

   task automatic test_leading_zero();
      logic [31:0] tbl;
      bcd_in = 16'h0005; dp_in = 4'b0100; blink_en = 4'h0; lz_blank = 1'b1; brightness = 3'd7;
      apply_reset();
      for (int f = 0; f < 2; f++) begin
         tbl = (f == 0) ? 32'hFFFFFFC0 : 32'hFF7FFF92;
         for (int i = 0; i < 64; i++) begin
            step();
            n_cmp++;
            if (seg_sel !== exp_sel(cnt, 3'd7, 4'h0) || seg_out !== exp_out(cnt, tbl)) begin
               n_bad++;
               $display("FAIL lz f%0d c%0d: sel=%b out=%h want sel=%b out=%h",
                        f, cnt, seg_sel, seg_out, exp_sel(cnt, 3'd7, 4'h0), exp_out(cnt, tbl));
            end
         end
      end
   endtask

   task automatic test_brightness();
      int on_cnt;
      bcd_in = 16'h1234; dp_in = 4'h0; blink_en = 4'h0; lz_blank = 1'b0;
      for (int b = 0; b < 2; b++) begin
         brightness = (b == 0) ? 3'd0 : 3'd3;
         apply_reset();
         on_cnt = 0;
         for (int i = 0; i < 64; i++) begin
            step();
            if (seg_sel !== 4'hF) on_cnt++;
            n_cmp++;
            if (seg_sel !== exp_sel(cnt, brightness, 4'h0) || seg_out !== 8'hC0) begin
               n_bad++;
               $display("FAIL bright%0d c%0d: sel=%b out=%h want sel=%b out=c0",
                        brightness, cnt, seg_sel, seg_out, exp_sel(cnt, brightness, 4'h0));
            end
         end
         n_cmp++;
         if (on_cnt != ((b == 0) ? 8 : 32)) begin
            n_bad++;
            $display("FAIL bright_oncount%0d: got %0d want %0d", brightness, on_cnt, (b == 0) ? 8 : 32);
         end
      end
   endtask

   task automatic test_blink();
      int d3_on;
      bcd_in = 16'h1234; dp_in = 4'h0; blink_en = 4'b1010; lz_blank = 1'b0; brightness = 3'd7;
      apply_reset();
      d3_on = 0;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 64; i++) begin
            step();
            if (f == 1 && i >= 48 && seg_sel !== 4'hF) d3_on++;
            n_cmp++;
            if (seg_sel !== exp_sel(cnt, 3'd7, (f == 0) ? 4'h0 : 4'b1010)) begin
               n_bad++;
               $display("FAIL blink f%0d c%0d: sel=%b want %b",
                        f, cnt, seg_sel, exp_sel(cnt, 3'd7, (f == 0) ? 4'h0 : 4'b1010));
            end
         end
      end
      n_cmp++;
      if (d3_on != 0) begin
         n_bad++;
         $display("FAIL blink_digit3_dark: lit cycles %0d want 0", d3_on);
      end
   endtask

   task automatic test_invalid_bcd();
      bcd_in = 16'h000A; dp_in = 4'h0; blink_en = 4'h0; lz_blank = 1'b0; brightness = 3'd7;
      apply_reset();
      repeat (64) step();
      for (int i = 0; i < 64; i++) begin
         step();
         n_cmp++;
         if (seg_out !== exp_out(cnt, 32'hC0C0C0BF)) begin
            n_bad++;
            $display("FAIL invalid c%0d: out=%h want %h", cnt, seg_out, exp_out(cnt, 32'hC0C0C0BF));
         end
      end
   endtask

   task automatic test_mid_reset();
      bcd_in = 16'h1234; dp_in = 4'hF; blink_en = 4'h0; lz_blank = 1'b0; brightness = 3'd7;
      apply_reset();
      repeat (103) step();
      n_cmp++;
      if (seg_out !== 8'h24) begin
         n_bad++;
         $display("FAIL midreset_pre: out=%h want 24", seg_out);
      end
      rst = 1'b1;
      step();
      n_cmp++;
      if (seg_sel !== 4'hF || seg_out !== 8'hFF) begin
         n_bad++;
         $display("FAIL midreset_hit: sel=%b out=%h want 1111 ff", seg_sel, seg_out);
      end
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (seg_sel !== 4'b1110 || seg_out !== 8'hC0) begin
            n_bad++;
            $display("FAIL midreset_restart c%0d: sel=%b out=%h want 1110 c0", cnt, seg_sel, seg_out);
         end
      end
   endtask

   initial begin
      rst = 1'b1; bcd_in = '0; dp_in = '0; blink_en = '0; lz_blank = 1'b0; brightness = 3'd7;
      test_reset();
      test_scan();
      test_leading_zero();
      test_brightness();
      test_blink();
      test_invalid_bcd();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
